// File: rtl/motoro3_phase_seq.sv
// motoro3_phase_seq
// Six-step three-phase commutation sequencer. The divided clkM3 reference is
// synchronised and edge-detected into single-cycle ticks. Every max(stepDiv,1)
// ticks the step index advances, and each advance is followed by DEAD_CYC
// cycles with all gates off before the new table pattern is driven. All
// outputs come straight from flops.
module motoro3_phase_seq #(
  parameter int unsigned DEAD_CYC = 4  // legal range 1..255
) (
  input  logic        clk50mhz,
  input  logic        nRst,
  input  logic        clkM3,
  input  logic        enable,
  input  logic        dir,
  input  logic [15:0] stepDiv,
  output logic        phA_hi,
  output logic        phA_lo,
  output logic        phB_hi,
  output logic        phB_lo,
  output logic        phC_hi,
  output logic        phC_lo,
  output logic [2:0]  stepIdx,
  output logic        stepStrobe,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYC);

  // Gate pattern per step, packed as {A_hi, A_lo, B_hi, B_lo, C_hi, C_lo}.
  function automatic logic [5:0] comm_pattern(input logic [2:0] idx);
    logic [5:0] pat;
    case (idx)
      3'd0:    pat = 6'b10_01_00;  // A_hi + B_lo
      3'd1:    pat = 6'b10_00_01;  // A_hi + C_lo
      3'd2:    pat = 6'b00_10_01;  // B_hi + C_lo
      3'd3:    pat = 6'b01_10_00;  // B_hi + A_lo
      3'd4:    pat = 6'b01_00_10;  // C_hi + A_lo
      3'd5:    pat = 6'b00_01_10;  // C_hi + B_lo
      default: pat = 6'b00_00_00;  // unreachable indices keep every gate off
    endcase
    return pat;
  endfunction

  // Modulo-6 step in either direction.
  function automatic logic [2:0] next_step(input logic [2:0] idx, input logic fwd);
    logic [2:0] nxt;
    if (fwd) begin
      nxt = (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      nxt = (idx == 3'd0 || idx > 3'd5) ? 3'd5 : idx - 3'd1;
    end
    return nxt;
  endfunction

  logic        sync1_q, sync2_q, dly_q;
  state_e      state_q, state_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]  dead_cnt_q, dead_cnt_d;
  logic [2:0]  step_q, step_d;
  logic        strobe_q, strobe_d;
  logic [5:0]  gates_q, gates_d;
  logic        busy_q, busy_d;

  logic        tick_s;
  logic [15:0] div_m1_s;
  logic        adv_s;

  // One cycle per clkM3 rising edge, seen after synchronisation.
  assign tick_s   = sync2_q & ~dly_q;
  // Terminal count; stepDiv of 0 behaves like 1.
  assign div_m1_s = (stepDiv == 16'd0) ? 16'd0 : stepDiv - 16'd1;
  // Advance only while running; enable low overrides it in the FSM below.
  assign adv_s    = tick_s && (state_q != ST_IDLE) && (tick_cnt_q >= div_m1_s);

  // Synchroniser and edge-detect delay for the asynchronous clkM3 reference.
  always_ff @(posedge clk50mhz or negedge nRst) begin
    if (!nRst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= clkM3;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  // Next-state logic: FSM, tick counter, dead counter and step index.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    dead_cnt_d = dead_cnt_q;
    step_d     = step_q;
    strobe_d   = 1'b0;

    if (!enable) begin
      state_d    = ST_IDLE;
      tick_cnt_d = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_DEAD;
          dead_cnt_d = DEAD_LOAD;
          tick_cnt_d = 16'd0;
        end
        ST_DEAD, ST_DRIVE: begin
          if (adv_s) begin
            tick_cnt_d = 16'd0;
            step_d     = next_step(step_q, dir);
            strobe_d   = 1'b1;
            state_d    = ST_DEAD;
            dead_cnt_d = DEAD_LOAD;
          end else begin
            if (tick_s) begin
              tick_cnt_d = tick_cnt_q + 16'd1;
            end else begin
              tick_cnt_d = tick_cnt_q;
            end
            if (state_q == ST_DEAD) begin
              dead_cnt_d = dead_cnt_q - 8'd1;
              if (dead_cnt_q <= 8'd1) begin
                state_d    = ST_DRIVE;
                dead_cnt_d = 8'd0;
              end else begin
                state_d = ST_DEAD;
              end
            end else begin
              state_d = ST_DRIVE;
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          tick_cnt_d = 16'd0;
        end
      endcase
    end

    // Gates follow the next state so they drop on the same edge as a step change.
    if (state_d == ST_DRIVE) begin
      gates_d = comm_pattern(step_d);
    end else begin
      gates_d = 6'b00_00_00;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk50mhz or negedge nRst) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= 16'd0;
      dead_cnt_q <= 8'd0;
      step_q     <= 3'd0;
      strobe_q   <= 1'b0;
      gates_q    <= 6'b00_00_00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      step_q     <= step_d;
      strobe_q   <= strobe_d;
      gates_q    <= gates_d;
      busy_q     <= busy_d;
    end
  end

  assign phA_hi     = gates_q[5];
  assign phA_lo     = gates_q[4];
  assign phB_hi     = gates_q[3];
  assign phB_lo     = gates_q[2];
  assign phC_hi     = gates_q[1];
  assign phC_lo     = gates_q[0];
  assign stepIdx    = step_q;
  assign stepStrobe = strobe_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_motoro3_phase_seq.sv
// Bench for motoro3_phase_seq: a behavioural reference model predicts the
// outputs after every clock edge and queues them; a monitor pops and compares.
// A second instance with a 12-cycle dead time covers the dead > step case.
`timescale 1ns/1ps
module tb_motoro3_phase_seq;

  localparam int DEAD_A  = 4;
  localparam int DEAD_B  = 12;
  // clkM3 rises 5 ns after every clock edge whose count is a multiple of 10;
  // after two synchroniser stages the advance lands on the third edge.
  localparam int TICK_AT = 3;

  logic        clk50mhz = 1'b0;
  logic        nRst     = 1'b0;
  logic        clkM3    = 1'b0;
  logic        enable   = 1'b0;
  logic        en_b     = 1'b0;
  logic        dir      = 1'b1;
  logic [15:0] stepDiv  = 16'd3;

  logic       phA_hi, phA_lo, phB_hi, phB_lo, phC_hi, phC_lo;
  logic [2:0] stepIdx;
  logic       stepStrobe, busy;
  logic       b_ahi, b_alo, b_bhi, b_blo, b_chi, b_clo;
  logic [2:0] b_idx;
  logic       b_strobe, b_busy;

  motoro3_phase_seq #(.DEAD_CYC(DEAD_A)) u_dut (
    .clk50mhz(clk50mhz), .nRst(nRst), .clkM3(clkM3), .enable(enable),
    .dir(dir), .stepDiv(stepDiv),
    .phA_hi(phA_hi), .phA_lo(phA_lo), .phB_hi(phB_hi), .phB_lo(phB_lo),
    .phC_hi(phC_hi), .phC_lo(phC_lo),
    .stepIdx(stepIdx), .stepStrobe(stepStrobe), .busy(busy)
  );

  motoro3_phase_seq #(.DEAD_CYC(DEAD_B)) u_dut_b (
    .clk50mhz(clk50mhz), .nRst(nRst), .clkM3(clkM3), .enable(en_b),
    .dir(dir), .stepDiv(stepDiv),
    .phA_hi(b_ahi), .phA_lo(b_alo), .phB_hi(b_bhi), .phB_lo(b_blo),
    .phC_hi(b_chi), .phC_lo(b_clo),
    .stepIdx(b_idx), .stepStrobe(b_strobe), .busy(b_busy)
  );

  always #10 clk50mhz = ~clk50mhz;

  // 5 MHz reference with 50% duty, offset from the clock edges.
  int gen_n = 0;
  always @(posedge clk50mhz) begin
    gen_n = gen_n + 1;
    #5;
    clkM3 = ((gen_n % 10) < 5);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected gates {A_hi,A_lo,B_hi,B_lo,C_hi,C_lo} from which phase is high/low.
  function automatic logic [5:0] exp_pattern(input int s);
    int hi_ph [6] = '{0, 0, 1, 1, 2, 2};
    int lo_ph [6] = '{1, 2, 2, 0, 0, 1};
    logic [5:0] g;
    g = 6'd0;
    g[5 - 2 * hi_ph[s]] = 1'b1;
    g[4 - 2 * lo_ph[s]] = 1'b1;
    return g;
  endfunction

  typedef struct packed {
    logic [5:0] gates;
    logic       busy;
    logic [2:0] idx;
    logic       strobe;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: running flag, ticks since last advance, dead cycles left.
  int m_edge = 0;
  bit m_active = 1'b0;
  int m_ticks = 0;
  int m_dead_left = 0;
  int m_step = 0;
  always @(posedge clk50mhz) begin
    exp_t e;
    bit adv;
    int div;
    m_edge++;
    adv = 1'b0;
    if (!nRst) begin
      m_active = 1'b0; m_ticks = 0; m_dead_left = 0; m_step = 0;
    end else if (!enable) begin
      m_active = 1'b0; m_ticks = 0;
    end else if (!m_active) begin
      m_active = 1'b1; m_ticks = 0; m_dead_left = DEAD_A;
    end else begin
      div = (stepDiv == 16'd0) ? 1 : int'(stepDiv);
      if ((m_edge % 10) == TICK_AT) begin
        m_ticks++;
        if (m_ticks >= div) begin
          adv = 1'b1;
          m_ticks = 0;
          m_step = dir ? (m_step + 1) % 6 : (m_step + 5) % 6;
          m_dead_left = DEAD_A;
        end
      end
      if (!adv && m_dead_left > 0) m_dead_left--;
    end
    e.gates  = (m_active && m_dead_left == 0) ? exp_pattern(m_step) : 6'd0;
    e.busy   = m_active;
    e.idx    = 3'(m_step);
    e.strobe = adv;
    exp_q.push_back(e);
  end

  // Monitor: compare every presented cycle against the queued prediction.
  always @(negedge clk50mhz) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("gates", {26'd0, phA_hi, phA_lo, phB_hi, phB_lo, phC_hi, phC_lo}, {26'd0, e.gates});
      chk("busy", {31'd0, busy}, {31'd0, e.busy});
      chk("stepIdx", {29'd0, stepIdx}, {29'd0, e.idx});
      chk("stepStrobe", {31'd0, stepStrobe}, {31'd0, e.strobe});
    end
    chk("hi_lo_overlap", {29'd0, phA_hi & phA_lo, phB_hi & phB_lo, phC_hi & phC_lo}, 32'd0);
  end

  // Long-dead-time instance: gates never on, strobes every tick, steps +1.
  int neg_n = 0;
  int b_last = -1;
  int b_prev_idx = 0;
  int b_strobes = 0;
  always @(negedge clk50mhz) begin
    neg_n++;
    chk("b_gates_zero", {26'd0, b_ahi, b_alo, b_bhi, b_blo, b_chi, b_clo}, 32'd0);
    if (b_strobe) begin
      if (b_last >= 0) begin
        chk("b_period", neg_n - b_last, 32'd10);
        chk("b_idx", {29'd0, b_idx}, (b_prev_idx + 1) % 6);
      end
      b_last = neg_n;
      b_prev_idx = int'(b_idx);
      b_strobes++;
    end
  end

  task automatic wait_strobes(input int n, input int budget);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk50mhz);
      cyc++;
      if (stepStrobe) seen++;
    end
    chk("strobe_budget", seen, n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // Reset with clkM3 running, then idle with enable low.
    repeat (4) @(negedge clk50mhz);
    nRst = 1'b1;
    repeat (30) @(negedge clk50mhz);

    // Forward run from step 0: eight advances lands on step 2.
    stepDiv = 16'd3; dir = 1'b1; enable = 1'b1;
    wait_strobes(8, 8 * 30 + 40);
    chk("fwd_end_idx", {29'd0, stepIdx}, 32'd2);
    // Reverse from 2: 1, 0, 5.
    dir = 1'b0;
    wait_strobes(3, 3 * 30 + 10);
    chk("rev_end_idx", {29'd0, stepIdx}, 32'd5);
    // Flip to forward mid-step: 0, then 1.
    repeat (15) @(negedge clk50mhz);
    dir = 1'b1;
    wait_strobes(2, 2 * 30 + 10);
    chk("flip_end_idx", {29'd0, stepIdx}, 32'd1);

    // stepDiv 0 and 1 both advance every tick.
    stepDiv = 16'd0;
    repeat (100) @(negedge clk50mhz);
    stepDiv = 16'd1;
    repeat (100) @(negedge clk50mhz);

    // Dead time longer than the step on the second instance.
    en_b = 1'b1;
    repeat (120) @(negedge clk50mhz);
    en_b = 1'b0;
    chk("b_strobe_count", (b_strobes >= 10) ? 32'd1 : 32'd0, 32'd1);

    // Randomised enable/dir/stepDiv traffic.
    for (int i = 0; i < 150; i++) begin
      enable  = ($urandom_range(0, 9) < 8);
      dir     = 1'($urandom_range(0, 1));
      stepDiv = 16'($urandom_range(0, 3));
      repeat ($urandom_range(1, 60)) @(negedge clk50mhz);
    end

    // Drop enable while driving, then resume.
    stepDiv = 16'd3; dir = 1'b1; enable = 1'b1;
    cnt = 0;
    while ({phA_hi, phA_lo, phB_hi, phB_lo, phC_hi, phC_lo} == 6'd0 && cnt < 80) begin
      @(negedge clk50mhz);
      cnt++;
    end
    chk("reach_drive", (cnt < 80) ? 32'd1 : 32'd0, 32'd1);
    enable = 1'b0;
    @(negedge clk50mhz);
    chk("disable_gates", {26'd0, phA_hi, phA_lo, phB_hi, phB_lo, phC_hi, phC_lo}, 32'd0);
    chk("disable_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk50mhz);
    enable = 1'b1;
    repeat (60) @(negedge clk50mhz);

    // Reset pulse in the middle of a dead period.
    enable = 1'b0;
    repeat (5) @(negedge clk50mhz);
    enable = 1'b1;
    repeat (2) @(negedge clk50mhz);
    #2;
    nRst = 1'b0;
    #1;
    chk("rst_gates", {26'd0, phA_hi, phA_lo, phB_hi, phB_lo, phC_hi, phC_lo}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_idx", {29'd0, stepIdx}, 32'd0);
    chk("rst_strobe", {31'd0, stepStrobe}, 32'd0);
    enable = 1'b0;
    repeat (3) @(negedge clk50mhz);
    nRst = 1'b1;
    repeat (30) @(negedge clk50mhz);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/motoro3_phase_seq.md
# motoro3_phase_seq

Six-step three-phase commutation sequencer for the motor drive. It sits directly downstream of the 5 MHz `clkM3` divider. `clkM3` is treated as a timing reference, not as a clock: the block synchronizes it, counts its rising edges, and advances a commutation step every `stepDiv` ticks. Between steps it inserts dead time and drives six registered gate-enable outputs, a high-side and a low-side output per phase.

## Interface
- `DEAD_CYC`, default 4: dead-time length in `clk50mhz` cycles; legal range 1..255.
- `clk50mhz`  in  1  system clock; all logic is on the rising edge.
- `nRst`  in  1  reset, asynchronous, active-low.
- `clkM3`  in  1  divided reference (5 MHz, 50% duty); asynchronous to this block's logic.
- `enable`  in  1  run request; level-sensitive.
- `dir`  in  1  direction: 1 = forward (step +1), 0 = reverse (step −1).
- `stepDiv`  in  16  `clkM3` ticks per commutation step; value 0 is treated as 1.
- `phA_hi`, `phA_lo`, `phB_hi`, `phB_lo`, `phC_hi`, `phC_lo`  out  1 each  gate enables; registered.
- `stepIdx`  out  3  current commutation step, range 0..5.
- `stepStrobe`  out  1  one-cycle pulse on each step advance.
- `busy`  out  1  high while the state is not IDLE.

## Operation
- **Tick detection**
  - `clkM3` passes through a 2-flop synchronizer, then a delay register.
  - `tick` = synced & ~delayed: one `clk50mhz` cycle per `clkM3` rising edge.
- **Tick counter** (16-bit `tickCnt`)
  - Runs only in DEAD or DRIVE.
  - On `tick`: if `tickCnt` >= max(`stepDiv`,1) − 1, then `tickCnt` ← 0 and an advance occurs. Otherwise `tickCnt` increments.
  - The comparison is unsigned. The counter never wraps, because the compare bounds it.
- **Advance**
  - `stepIdx` ← (`stepIdx` + 1) mod 6 when `dir` = 1, so 5 → 0.
  - `stepIdx` ← (`stepIdx` + 5) mod 6 when `dir` = 0, so 0 → 5.
  - `stepStrobe` = 1 for that cycle.
  - `dir` is sampled at the advance, so a direction change takes effect on the next advance.
- **Commutation table** (all other outputs 0):
  - step 0: A_hi + B_lo
  - step 1: A_hi + C_lo
  - step 2: B_hi + C_lo
  - step 3: B_hi + A_lo
  - step 4: C_hi + A_lo
  - step 5: C_hi + B_lo
- **FSM: IDLE**
  - All six outputs 0; `tickCnt` held at 0; `stepIdx` retained.
  - `enable` = 1 → DEAD, with the dead counter loaded to `DEAD_CYC`.
- **FSM: DEAD**
  - All six outputs 0; the dead counter decrements each cycle.
  - On reaching 1 → DRIVE.
  - An advance during DEAD updates `stepIdx` and reloads the dead counter to `DEAD_CYC`.
- **FSM: DRIVE**
  - Outputs = table[`stepIdx`].
  - An advance → DEAD (dead counter = `DEAD_CYC`), and outputs go to 0 on the same registered edge as the `stepIdx` update.
- **`enable` = 0 in any state** → IDLE on the next edge: outputs 0 and `tickCnt` ← 0. This has priority over an advance in the same cycle.
- **Invariant:** hi and lo of the same phase are never both 1, and never transition 1→1 across a step change.

## Timing
- **Reset values:** all phase outputs 0, `stepIdx` = 0, `stepStrobe` = 0, `busy` = 0, state IDLE, `tickCnt` = 0, synchronizer and delay flops 0, dead counter 0.
- **Tick latency:** `tick` pulses 2–3 `clk50mhz` cycles after a `clkM3` rising edge.
- **Enable to first drive:**
  - `enable` sampled high at edge k → state DEAD and `busy` = 1 after edge k.
  - Outputs are 0 for exactly `DEAD_CYC` cycles.
  - The table pattern appears after edge k + `DEAD_CYC`.
- **Step period:** max(`stepDiv`,1) `clkM3` periods.
  - Each step drives for (period − `DEAD_CYC`) cycles.
  - Example: 5 MHz `clkM3`, `stepDiv` = 3 → 30 cycles per step, 26 driven.
- **`stepDiv` changes** take effect at the next tick compare; no restart occurs.
- **Dead time longer than the step:** if `DEAD_CYC` ≥ the step period, the outputs stay 0 continuously. This is legal and must not glitch.
- **Mid-operation reset:** asynchronous clear to the reset values above; outputs drop within the same instant.

## Test plan
- **Reset with free-running clocks:** `clkM3` running, `enable` = 0 → all outputs 0, `busy` = 0, `stepIdx` = 0, no `stepStrobe`.
- **Forward run:** `DEAD_CYC` = 4, `stepDiv` = 3, `dir` = 1, `enable` ↑.
  - 4 cycles of zero output, then A_hi/B_lo.
  - `stepIdx` sequence 0,1,2,3,4,5,0, one advance every 30 cycles.
  - Each advance gives 4 zero cycles before the new pattern.
  - Checker asserts hi & lo never both set on any phase.
- **Reverse and direction flip:** start at `stepIdx` = 2 with `dir` = 0 → 1,0,5. Flip `dir` to 1 mid-step → next step is 0, then 1.
- **`stepDiv` = 0 and 1:** both advance on every tick (every 10 cycles); each step drives for 6 cycles with `DEAD_CYC` = 4.
- **Dead time exceeds step:** `DEAD_CYC` = 12, `stepDiv` = 1 → outputs remain 0, while `stepIdx` and `stepStrobe` still advance every 10 cycles.
- **Disable and reset mid-run:**
  - Drop `enable` in DRIVE → outputs 0 and IDLE on the next edge; `stepIdx` is retained.
  - Re-enable → resumes at the retained step after `DEAD_CYC` cycles.
  - Pulse `nRst` low mid-DEAD → immediate reset values.
